vga_scanout: RTL

Display-side reader of the rasterizer's framebuffer. Generates 640x480@60 VGA timing from a 25 MHz pixel clock and issues framebuffer read addresses at VERT_RESOLUTION x HORIZ_RESOLUTION, replicating each stored pixel SCALE x SCALE times. Drives 12-bit RGB plus active-low sync to the DAC/pins. It also exports vertical-blank status so the draw side knows when it can safely write.

---
 rtl/vga_scanout_if.sv | 57 +++++
 rtl/vga_scanout.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_scanout_if.sv
// ---------------------------------------------------------------------------
// vga_scanout_if
//
// Signal bundle between the VGA scanout engine, its framebuffer and the pins.
//
// Parameters:
//   VERT_W   width of the framebuffer row address
//   HORIZ_W  width of the framebuffer column address
//
// Signals:
//   i_enable          colour enable (low forces black, timing keeps running)
//   o_vert_read_addr  framebuffer row address
//   o_horiz_read_addr framebuffer column address
//   o_read_en         framebuffer read strobe (memory has 1-cycle latency)
//   i_red/green/blue  framebuffer read data, 4 bits each
//   o_red/green/blue  VGA colour, 4 bits each
//   o_hsync/o_vsync   active-low sync
//   o_vblank          line counter is in the vertical blanking region
//   o_frame_start     one-cycle pulse when the counters wrap to (0,0)
//
// Modports:
//   master  the scanout engine
//   slave   the framebuffer / pin side
// ---------------------------------------------------------------------------
interface vga_scanout_if #(
    parameter int VERT_W  = 6,
    parameter int HORIZ_W = 7
);
    logic               i_enable;
    logic [VERT_W-1:0]  o_vert_read_addr;
    logic [HORIZ_W-1:0] o_horiz_read_addr;
    logic               o_read_en;
    logic [3:0]         i_red;
    logic [3:0]         i_green;
    logic [3:0]         i_blue;
    logic [3:0]         o_red;
    logic [3:0]         o_green;
    logic [3:0]         o_blue;
    logic               o_hsync;
    logic               o_vsync;
    logic               o_vblank;
    logic               o_frame_start;

    modport master (
        input  i_enable, i_red, i_green, i_blue,
        output o_vert_read_addr, o_horiz_read_addr, o_read_en,
        output o_red, o_green, o_blue, o_hsync, o_vsync,
        output o_vblank, o_frame_start
    );

    modport slave (
        output i_enable, i_red, i_green, i_blue,
        input  o_vert_read_addr, o_horiz_read_addr, o_read_en,
        input  o_red, o_green, o_blue, o_hsync, o_vsync,
        input  o_vblank, o_frame_start
    );
endinterface

// File: rtl/vga_scanout.sv
// ---------------------------------------------------------------------------
// vga_scanout
//
// Reads the rasterizer's framebuffer and drives a 640x480@60 VGA output from
// a 25 MHz pixel clock. Each stored pixel is replicated SCALE x SCALE times.
// Pipeline: counters (t) -> address/read strobe (t+1) -> memory data (t+2)
// -> registered colour (t+3). Sync is delayed to stay aligned with colour.
// o_vblank and o_frame_start are taken straight from the counter stage so
// the draw side gets an early warning.
//
// Optional feature: define SCANOUT_TEST_PATTERN_EN to replace framebuffer
// colour with 8 vertical colour bars (read strobe held low, addresses still
// count, timing unchanged).
//
// Ports:
//   i_clk   pixel clock
//   i_arst  asynchronous reset, active-high
//   bus     vga_scanout_if.master (framebuffer read, colour, sync, status)
// ---------------------------------------------------------------------------
module vga_scanout #(
    parameter int VERT_RESOLUTION  = 60,
    parameter int HORIZ_RESOLUTION = 80,
    parameter int SCALE            = 8,
    parameter int H_VISIBLE        = HORIZ_RESOLUTION * SCALE,
    parameter int H_FRONT          = 16,
    parameter int H_SYNC           = 96,
    parameter int H_BACK           = 48,
    parameter int V_VISIBLE        = VERT_RESOLUTION * SCALE,
    parameter int V_FRONT          = 10,
    parameter int V_SYNC           = 2,
    parameter int V_BACK           = 33
) (
    input  logic          i_clk,
    input  logic          i_arst,
    vga_scanout_if.master bus
);
    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int HC_W    = $clog2(H_TOTAL);
    localparam int VC_W    = $clog2(V_TOTAL);
    localparam int HA_W    = $clog2(HORIZ_RESOLUTION);
    localparam int VA_W    = $clog2(VERT_RESOLUTION);
    localparam int SUB_W   = (SCALE > 1) ? $clog2(SCALE) : 1;

    // Counter stage
    logic [HC_W-1:0]  h_cnt_r;
    logic [VC_W-1:0]  v_cnt_r;
    logic [SUB_W-1:0] h_sub_r;
    logic [SUB_W-1:0] v_sub_r;
    logic [HA_W-1:0]  col_cnt_r;
    logic [VA_W-1:0]  row_cnt_r;
    logic             vblank_r;
    logic             frame_start_r;

    logic             h_last_s;
    logic             v_last_s;
    logic             h_act_s;
    logic             v_act_s;
    logic             active_s;
    logic             hsync_s;
    logic             vsync_s;
    logic [VC_W-1:0]  v_next_s;

    // Address / delay stage
    logic [HA_W-1:0]  horiz_addr_r;
    logic [VA_W-1:0]  vert_addr_r;
    logic             read_en_r;
    logic [2:0]       hsync_d_r;
    logic [2:0]       vsync_d_r;
    logic [1:0]       active_d_r;

    // Colour stage
    logic [3:0]       red_r;
    logic [3:0]       green_r;
    logic [3:0]       blue_r;
    logic [3:0]       src_red_s;
    logic [3:0]       src_green_s;
    logic [3:0]       src_blue_s;

    // Decode of the current counter position
    always_comb begin
        h_last_s = (h_cnt_r == HC_W'(H_TOTAL - 1));
        v_last_s = (v_cnt_r == VC_W'(V_TOTAL - 1));
        h_act_s  = (h_cnt_r < HC_W'(H_VISIBLE));
        v_act_s  = (v_cnt_r < VC_W'(V_VISIBLE));
        active_s = h_act_s && v_act_s;
        hsync_s  = ~((h_cnt_r >= HC_W'(H_VISIBLE + H_FRONT)) &&
                     (h_cnt_r <  HC_W'(H_VISIBLE + H_FRONT + H_SYNC)));
        vsync_s  = ~((v_cnt_r >= VC_W'(V_VISIBLE + V_FRONT)) &&
                     (v_cnt_r <  VC_W'(V_VISIBLE + V_FRONT + V_SYNC)));
        v_next_s = v_cnt_r;
        if (h_last_s) begin
            if (v_last_s) begin
                v_next_s = {VC_W{1'b0}};
            end else begin
                v_next_s = v_cnt_r + VC_W'(1);
            end
        end else begin
            v_next_s = v_cnt_r;
        end
    end

    // Raster counters plus the undelayed status flags
    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            h_cnt_r       <= {HC_W{1'b0}};
            v_cnt_r       <= {VC_W{1'b0}};
            vblank_r      <= 1'b0;
            frame_start_r <= 1'b0;
        end else begin
            if (h_last_s) begin
                h_cnt_r <= {HC_W{1'b0}};
            end else begin
                h_cnt_r <= h_cnt_r + HC_W'(1);
            end
            v_cnt_r       <= v_next_s;
            // Flags describe the position the counters hold next cycle
            vblank_r      <= (v_next_s >= VC_W'(V_VISIBLE));
            frame_start_r <= h_last_s && v_last_s;
        end
    end

    // Column sub-counter: col_cnt_r tracks h_cnt_r / SCALE without a divider
    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            h_sub_r   <= {SUB_W{1'b0}};
            col_cnt_r <= {HA_W{1'b0}};
        end else if (h_last_s) begin
            h_sub_r   <= {SUB_W{1'b0}};
            col_cnt_r <= {HA_W{1'b0}};
        end else if (h_act_s) begin
            if (h_sub_r == SUB_W'(SCALE - 1)) begin
                h_sub_r <= {SUB_W{1'b0}};
                // Saturate so the last visible clock cannot step past the end
                if (col_cnt_r != HA_W'(HORIZ_RESOLUTION - 1)) begin
                    col_cnt_r <= col_cnt_r + HA_W'(1);
                end else begin
                    col_cnt_r <= col_cnt_r;
                end
            end else begin
                h_sub_r <= h_sub_r + SUB_W'(1);
            end
        end else begin
            h_sub_r   <= h_sub_r;
            col_cnt_r <= col_cnt_r;
        end
    end

    // Row sub-counter: row_cnt_r tracks v_cnt_r / SCALE, stepped at line end
    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            v_sub_r   <= {SUB_W{1'b0}};
            row_cnt_r <= {VA_W{1'b0}};
        end else if (h_last_s && v_last_s) begin
            v_sub_r   <= {SUB_W{1'b0}};
            row_cnt_r <= {VA_W{1'b0}};
        end else if (h_last_s && v_act_s) begin
            if (v_sub_r == SUB_W'(SCALE - 1)) begin
                v_sub_r <= {SUB_W{1'b0}};
                if (row_cnt_r != VA_W'(VERT_RESOLUTION - 1)) begin
                    row_cnt_r <= row_cnt_r + VA_W'(1);
                end else begin
                    row_cnt_r <= row_cnt_r;
                end
            end else begin
                v_sub_r <= v_sub_r + SUB_W'(1);
            end
        end else begin
            v_sub_r   <= v_sub_r;
            row_cnt_r <= row_cnt_r;
        end
    end

    // Read address and strobe; addresses hold outside the active region
    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            horiz_addr_r <= {HA_W{1'b0}};
            vert_addr_r  <= {VA_W{1'b0}};
            read_en_r    <= 1'b0;
        end else begin
            if (active_s) begin
                horiz_addr_r <= col_cnt_r;
                vert_addr_r  <= row_cnt_r;
            end else begin
                horiz_addr_r <= horiz_addr_r;
                vert_addr_r  <= vert_addr_r;
            end
`ifdef SCANOUT_TEST_PATTERN_EN
            read_en_r <= 1'b0;
`else
            read_en_r <= active_s;
`endif
        end
    end

    // Sync/active delay line keeping sync aligned with the colour register
    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            hsync_d_r  <= 3'b111;
            vsync_d_r  <= 3'b111;
            active_d_r <= 2'b00;
        end else begin
            hsync_d_r  <= {hsync_d_r[1:0], hsync_s};
            vsync_d_r  <= {vsync_d_r[1:0], vsync_s};
            active_d_r <= {active_d_r[0], active_s};
        end
    end

`ifdef SCANOUT_TEST_PATTERN_EN
    localparam int BAR_W   = H_VISIBLE / 8;
    localparam int BSUB_W  = (BAR_W > 1) ? $clog2(BAR_W) : 1;

    logic [BSUB_W-1:0] bar_sub_r;
    logic [2:0]        bar_idx_r;
    logic [2:0]        bar_d0_r;
    logic [2:0]        bar_d1_r;

    // Bar index follows h_cnt_r / BAR_W, then rides the pipeline to stage 3
    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            bar_sub_r <= {BSUB_W{1'b0}};
            bar_idx_r <= 3'd0;
            bar_d0_r  <= 3'd0;
            bar_d1_r  <= 3'd0;
        end else begin
            if (h_last_s) begin
                bar_sub_r <= {BSUB_W{1'b0}};
                bar_idx_r <= 3'd0;
            end else if (h_act_s) begin
                if (bar_sub_r == BSUB_W'(BAR_W - 1)) begin
                    bar_sub_r <= {BSUB_W{1'b0}};
                    if (bar_idx_r != 3'd7) begin
                        bar_idx_r <= bar_idx_r + 3'd1;
                    end else begin
                        bar_idx_r <= bar_idx_r;
                    end
                end else begin
                    bar_sub_r <= bar_sub_r + BSUB_W'(1);
                end
            end else begin
                bar_sub_r <= bar_sub_r;
                bar_idx_r <= bar_idx_r;
            end
            bar_d0_r <= bar_idx_r;
            bar_d1_r <= bar_d0_r;
        end
    end

    // Colour source: internal bar generator
    always_comb begin
        src_red_s   = {4{bar_d1_r[0]}};
        src_green_s = {4{bar_d1_r[1]}};
        src_blue_s  = {4{bar_d1_r[2]}};
    end
`else
    // Colour source: framebuffer read data
    always_comb begin
        src_red_s   = bus.i_red;
        src_green_s = bus.i_green;
        src_blue_s  = bus.i_blue;
    end
`endif

    // Colour output register; enable is sampled here for the pixel in flight
    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            red_r   <= 4'h0;
            green_r <= 4'h0;
            blue_r  <= 4'h0;
        end else if (active_d_r[1] && bus.i_enable) begin
            red_r   <= src_red_s;
            green_r <= src_green_s;
            blue_r  <= src_blue_s;
        end else begin
            red_r   <= 4'h0;
            green_r <= 4'h0;
            blue_r  <= 4'h0;
        end
    end

    assign bus.o_horiz_read_addr = horiz_addr_r;
    assign bus.o_vert_read_addr  = vert_addr_r;
    assign bus.o_read_en         = read_en_r;
    assign bus.o_red             = red_r;
    assign bus.o_green           = green_r;
    assign bus.o_blue            = blue_r;
    assign bus.o_hsync           = hsync_d_r[2];
    assign bus.o_vsync           = vsync_d_r[2];
    assign bus.o_vblank          = vblank_r;
    assign bus.o_frame_start     = frame_start_r;
endmodule
